// File: rtl/model_memory_write.sv
// model_memory_write: DNC write-head memory update, M' = M*(1 - w*e) + w*v, streamed row-major.
module model_memory_write #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FRACT_SIZE   = 32,
  parameter int MAX_W        = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic                 V_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] V_IN,
  input  logic                 E_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] E_IN,
  input  logic                 W_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] W_IN,
  input  logic                 M_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] M_IN,
  output logic                 M_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] M_OUT
);
  localparam int AW = MAX_W > 1 ? $clog2(MAX_W) : 1;
  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1) << FRACT_SIZE;
  localparam logic [CONTROL_SIZE-1:0] C1 = CONTROL_SIZE'(1);
  typedef enum logic [2:0] {IDLE, LOAD, ROW, COL, DONE} state_t;
  state_t state_q, state_d;
  logic [CONTROL_SIZE-1:0] n_q, n_d, w_q, w_d, kv_q, kv_d, ke_q, ke_d, j_q, j_d, k_q, k_d;
  logic [DATA_SIZE-1:0] wt_q, wt_d, m_out_q, m_out_d, t;
  logic ready_q, ready_d, m_en_q, m_en_d;
  logic [DATA_SIZE-1:0] vbuf_q [MAX_W];
  logic [DATA_SIZE-1:0] ebuf_q [MAX_W];
  logic [DATA_SIZE-1:0] w_clamp;
  logic [CONTROL_SIZE-1:0] n_in, w_in;
  logic [AW-1:0] idx;
  logic start_ok, zero, v_wr, e_wr, w_acc, m_acc, last_k, last_j;
  function automatic logic [DATA_SIZE-1:0] mul(input logic signed [DATA_SIZE-1:0] a,
                                               input logic signed [DATA_SIZE-1:0] b);
    logic signed [2*DATA_SIZE-1:0] p;
    p = (2*DATA_SIZE)'(a) * (2*DATA_SIZE)'(b);
    return DATA_SIZE'(p >>> FRACT_SIZE);
  endfunction
  assign w_clamp  = SIZE_W_IN > DATA_SIZE'(MAX_W) ? DATA_SIZE'(MAX_W) : SIZE_W_IN;
  assign n_in     = CONTROL_SIZE'(SIZE_N_IN);
  assign w_in     = CONTROL_SIZE'(w_clamp);
  assign start_ok = state_q == IDLE && START;
  assign zero     = n_in == '0 || w_in == '0;
  assign v_wr     = state_q == LOAD && V_IN_ENABLE && kv_q < w_q;
  assign e_wr     = state_q == LOAD && E_IN_ENABLE && ke_q < w_q;
  assign w_acc    = state_q == ROW && W_IN_ENABLE;
  assign m_acc    = state_q == COL && M_IN_ENABLE;
  assign last_k   = k_q == w_q - C1;
  assign last_j   = j_q == n_q - C1;
  assign idx      = k_q[AW-1:0];
  always_ff @(posedge CLK or posedge RST)
    if (RST) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = zero ? IDLE : LOAD;
      LOAD:    if (kv_q == w_q && ke_q == w_q) state_d = ROW;
      ROW:     if (W_IN_ENABLE) state_d = COL;
      COL:     if (M_IN_ENABLE && last_k) state_d = last_j ? DONE : ROW;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    t       = ONE - mul(wt_q, ebuf_q[idx]);
    ready_d = (start_ok && zero) || state_q == DONE;
    m_en_d  = m_acc;
    m_out_d = m_acc ? mul(M_IN, t) + mul(wt_q, vbuf_q[idx]) : m_out_q;
  end
  always_comb begin
    n_d  = start_ok ? n_in : n_q;
    w_d  = start_ok ? w_in : w_q;
    kv_d = start_ok ? '0 : v_wr ? kv_q + C1 : kv_q;
    ke_d = start_ok ? '0 : e_wr ? ke_q + C1 : ke_q;
    j_d  = start_ok ? '0 : (m_acc && last_k) ? j_q + C1 : j_q;
    k_d  = w_acc ? '0 : m_acc ? k_q + C1 : k_q;
    wt_d = w_acc ? W_IN : wt_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      {n_q, w_q, kv_q, ke_q, j_q, k_q} <= '0;
      {wt_q, m_out_q, ready_q, m_en_q} <= '0;
      for (int i = 0; i < MAX_W; i++) begin
        vbuf_q[i] <= '0;
        ebuf_q[i] <= '0;
      end
    end else begin
      {n_q, w_q, kv_q, ke_q, j_q, k_q} <= {n_d, w_d, kv_d, ke_d, j_d, k_d};
      {wt_q, m_out_q, ready_q, m_en_q} <= {wt_d, m_out_d, ready_d, m_en_d};
      if (v_wr) vbuf_q[kv_q[AW-1:0]] <= V_IN;
      if (e_wr) ebuf_q[ke_q[AW-1:0]] <= E_IN;
    end
  assign READY        = ready_q;
  assign M_OUT_ENABLE = m_en_q;
  assign M_OUT        = m_out_q;
endmodule

// File: tb/tb_model_memory_write.sv
// tb_model_memory_write: randomized scenarios against an arithmetic reference of the memory update.
module tb_model_memory_write;
  logic CLK = 0, RST = 1, START = 0, READY;
  logic [15:0] SIZE_N_IN = 0, SIZE_W_IN = 0;
  logic V_IN_ENABLE = 0, E_IN_ENABLE = 0, W_IN_ENABLE = 0, M_IN_ENABLE = 0, M_OUT_ENABLE;
  logic [15:0] V_IN = 0, E_IN = 0, W_IN = 0, M_IN = 0, M_OUT;
  int checks = 0, errors = 0, ready_cnt, bad_en, ready_lat;
  bit start_noise = 0;
  logic [15:0] vv [8];
  logic [15:0] ee [8];
  logic [15:0] ww [4];
  logic [15:0] mm [4][8];
  logic [15:0] got [$];
  logic [15:0] exp_q [$];

  model_memory_write #(.DATA_SIZE(16), .CONTROL_SIZE(16), .FRACT_SIZE(8), .MAX_W(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .SIZE_N_IN(SIZE_N_IN), .SIZE_W_IN(SIZE_W_IN),
    .V_IN_ENABLE(V_IN_ENABLE), .V_IN(V_IN), .E_IN_ENABLE(E_IN_ENABLE), .E_IN(E_IN),
    .W_IN_ENABLE(W_IN_ENABLE), .W_IN(W_IN), .M_IN_ENABLE(M_IN_ENABLE), .M_IN(M_IN),
    .M_OUT_ENABLE(M_OUT_ENABLE), .M_OUT(M_OUT));

  always #5 CLK = ~CLK;
  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] mulf(input logic signed [15:0] a, input logic signed [15:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return 16'(p >>> 8);
  endfunction

  task automatic build_exp(input int n, input int w);
    exp_q.delete();
    for (int j = 0; j < n; j++)
      for (int k = 0; k < w; k++)
        exp_q.push_back(16'(mulf(mm[j][k], 16'(256 - int'($signed(mulf(ww[j], ee[k]))))) + mulf(ww[j], vv[k])));
  endtask

  task automatic cyc();
    logic men;
    men = M_IN_ENABLE;
    @(posedge CLK); #1;
    if (M_OUT_ENABLE === 1'b1) got.push_back(M_OUT);
    if (M_OUT_ENABLE !== men) bad_en++;
    if (READY === 1'b1) ready_cnt++;
  endtask

  task automatic gap(input int hi);
    repeat ($urandom_range(hi, 0)) cyc();
  endtask

  task automatic start_op(input int n, input int w);
    got.delete(); ready_cnt = 0; bad_en = 0; ready_lat = -1;
    SIZE_N_IN = 16'(n); SIZE_W_IN = 16'(w); START = 1;
    cyc();
    START = 0;
  endtask

  task automatic load_ve(input int w, input int mode);
    if (mode == 0)
      for (int k = 0; k < w; k++) begin
        gap(1);
        V_IN_ENABLE = 1; V_IN = vv[k]; E_IN_ENABLE = 1; E_IN = ee[k];
        cyc();
        V_IN_ENABLE = 0; E_IN_ENABLE = 0;
      end
    else begin
      for (int k = 0; k < w; k++) begin V_IN_ENABLE = 1; V_IN = vv[k]; cyc(); end
      for (int k = 0; k < w; k++) begin
        V_IN = 16'h7777; W_IN_ENABLE = 1; W_IN = 16'h5A5A; E_IN_ENABLE = 1; E_IN = ee[k];
        cyc();
      end
      V_IN_ENABLE = 0; W_IN_ENABLE = 0; E_IN_ENABLE = 0;
    end
    cyc();
  endtask

  task automatic pulse_w(input logic [15:0] val);
    W_IN_ENABLE = 1; W_IN = val; cyc(); W_IN_ENABLE = 0;
  endtask

  task automatic pulse_m(input logic [15:0] val);
    M_IN_ENABLE = 1; M_IN = val; cyc(); M_IN_ENABLE = 0;
  endtask

  task automatic rows(input int n, input int w);
    for (int j = 0; j < n; j++) begin
      gap(2);
      pulse_w(ww[j]);
      for (int k = 0; k < w; k++) begin
        gap(1);
        if (start_noise && j == 0 && k == 0) begin START = 1; SIZE_N_IN = 5; SIZE_W_IN = 3; end
        pulse_m(mm[j][k]);
        START = 0;
      end
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (READY === 1'b1 && ready_lat < 0) ready_lat = i;
    end
  endtask

  task automatic randomize_data(input int n, input int w);
    for (int k = 0; k < w; k++) begin vv[k] = 16'($urandom); ee[k] = 16'($urandom); end
    for (int j = 0; j < n; j++) begin
      ww[j] = 16'($urandom);
      for (int k = 0; k < w; k++) mm[j][k] = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    checks++; if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", READY); end
    checks++; if (M_OUT_ENABLE !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", M_OUT_ENABLE); end
    checks++; if (M_OUT !== 16'h0) begin errors++; $display("FAIL reset_mout got %h want 0000", M_OUT); end
  endtask

  task automatic test_basic();
    vv[0] = 512; ee[0] = 256; ww[0] = 128; mm[0][0] = 256;
    start_op(1, 1); load_ve(1, 0); rows(1, 1);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL basic_count got %0d want 1", got.size()); end
    checks++; if (got.size() > 0 && got[0] !== 16'd384) begin errors++; $display("FAIL basic_value got %0d want 384", got[0]); end
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL basic_ready_cnt got %0d want 1", ready_cnt); end
    checks++; if (ready_lat != 1) begin errors++; $display("FAIL basic_ready_lat got %0d want 1", ready_lat); end
    checks++; if (bad_en != 0) begin errors++; $display("FAIL basic_en_timing got %0d want 0", bad_en); end
    checks++; if (M_OUT !== 16'd384) begin errors++; $display("FAIL basic_hold got %0d want 384", M_OUT); end
  endtask

  task automatic test_zero_weight();
    randomize_data(2, 3);
    ww[0] = 0; ww[1] = 0;
    start_op(2, 3); load_ve(3, 0); rows(2, 3);
    checks++; if (got.size() != 6) begin errors++; $display("FAIL zw_count got %0d want 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++; if (got[i] !== mm[i / 3][i % 3]) begin errors++; $display("FAIL zw_word%0d got %h want %h", i, got[i], mm[i / 3][i % 3]); end
    end
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL zw_ready_cnt got %0d want 1", ready_cnt); end
    checks++; if (bad_en != 0) begin errors++; $display("FAIL zw_en_timing got %0d want 0", bad_en); end
  endtask

  task automatic test_interleave();
    randomize_data(1, 2);
    start_op(1, 2); load_ve(2, 1); rows(1, 2); build_exp(1, 2);
    checks++; if (got.size() != 2) begin errors++; $display("FAIL il_count got %0d want 2", got.size()); end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL il_word%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL il_ready_cnt got %0d want 1", ready_cnt); end
  endtask

  task automatic test_zero_size();
    start_op(0, 3);
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL zn_ready got %0d want 1", ready_cnt); end
    repeat (3) cyc();
    checks++; if (ready_cnt != 1 || got.size() != 0 || bad_en != 0) begin
      errors++; $display("FAIL zn_quiet ready %0d outs %0d bad_en %0d want 1 0 0", ready_cnt, got.size(), bad_en); end
    start_op(2, 0);
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL zw0_ready got %0d want 1", ready_cnt); end
    randomize_data(1, 2);
    start_op(1, 2); load_ve(2, 0); rows(1, 2); build_exp(1, 2);
    checks++; if (got.size() != 2 || got[0] !== exp_q[0] || got[1] !== exp_q[1]) begin
      errors++; $display("FAIL zn_after outs %0d first %h want 2 %h", got.size(), got.size() > 0 ? got[0] : 16'hx, exp_q[0]); end
  endtask

  task automatic test_reset_mid();
    randomize_data(2, 2);
    ww[0] = 0; mm[0][0] = 16'h1234; mm[0][1] = 16'h4321;
    start_op(2, 2); load_ve(2, 0); pulse_w(ww[0]); pulse_m(mm[0][0]); pulse_m(mm[0][1]);
    checks++; if (M_OUT !== 16'h4321) begin errors++; $display("FAIL rm_before got %h want 4321", M_OUT); end
    RST = 1; #1;
    checks++; if (M_OUT !== 16'h0 || M_OUT_ENABLE !== 1'b0 || READY !== 1'b0) begin
      errors++; $display("FAIL rm_outputs mout %h en %b ready %b want 0 0 0", M_OUT, M_OUT_ENABLE, READY); end
    #1 RST = 0;
    ready_cnt = 0;
    repeat (3) cyc();
    checks++; if (ready_cnt != 0) begin errors++; $display("FAIL rm_no_ready got %0d want 0", ready_cnt); end
    randomize_data(1, 2);
    start_op(1, 2); load_ve(2, 0); rows(1, 2); build_exp(1, 2);
    checks++; if (got.size() != 2 || got[0] !== exp_q[0] || got[1] !== exp_q[1] || ready_cnt != 1) begin
      errors++; $display("FAIL rm_restart outs %0d ready %0d want 2 1", got.size(), ready_cnt); end
  endtask

  task automatic test_wrap();
    mm[0][0] = 16'd32767; ww[0] = 256; ee[0] = 0; vv[0] = 256;
    start_noise = 1;
    start_op(1, 1); load_ve(1, 0); rows(1, 1);
    start_noise = 0;
    checks++; if (got.size() != 1 || got[0] !== 16'h80FF) begin
      errors++; $display("FAIL wrap outs %0d value %h want 1 80ff", got.size(), got.size() > 0 ? got[0] : 16'hx); end
    repeat (3) cyc();
    checks++; if (ready_cnt != 1 || got.size() != 1) begin
      errors++; $display("FAIL wrap_start_ignored ready %0d outs %0d want 1 1", ready_cnt, got.size()); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int n, w, weff;
      n = $urandom_range(3, 1);
      w = (r == 4) ? 20 : $urandom_range(8, 1);
      weff = w > 8 ? 8 : w;
      randomize_data(n, weff);
      start_op(n, w); load_ve(weff, r % 2); rows(n, weff); build_exp(n, weff);
      checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", r, got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_word%0d got %h want %h", r, i, got[i], exp_q[i]); end
      end
      checks++; if (ready_cnt != 1 || ready_lat != 1 || bad_en != 0) begin
        errors++; $display("FAIL rnd%0d_ctrl ready %0d lat %0d bad_en %0d want 1 1 0", r, ready_cnt, ready_lat, bad_en); end
    end
  endtask

  initial begin
    #22 RST = 0;
    test_reset();
    test_basic();
    test_zero_weight();
    test_interleave();
    test_zero_size();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
